mem_march_ctrl: RTL and testbench
=================================

# mem_march_ctrl

March C- built-in self-test sequencer for the on-chip SRAM under test in the memory-test design. After a single `start` pulse it drives the memory port through six March elements over the full address space and compares every read against the expected background. It then reports pass/fail with the first failing address and element. It sits between the top-level command decode and the memory macro wrapper, and owns the memory port while `busy` is high.

## Interface

**Parameters**

- `ADDR_W`, default 6: memory address width; N = 2^ADDR_W words.
- `DATA_W`, default 8: memory word width.

**Ports**

- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a test; sampled only in IDLE or DONE.
- `busy`  out  1: test in progress; the memory port is owned by this block.
- `done`  out  1: test finished (pass or fail); sticky until the next accepted `start`.
- `fail`  out  1: mismatch detected; sticky until the next accepted `start`.
- `fail_addr`  out  ADDR_W: address of the first mismatching read.
- `fail_elem`  out  3: March element (0–5) of the first mismatch.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W: access address.
- `mem_wdata`  out  DATA_W: write data, either all zeros or all ones.
- `mem_rdata`  in  DATA_W: read data, valid the cycle after a read strobe.

## Operation

**States:** IDLE, RUN, CHECK, DONE.

- IDLE/DONE with `start`=1 → RUN at address 0, element 0. On that edge `done`, `fail`, `fail_addr` and `fail_elem` are cleared.

**Elements (D = all-zeros word, ~D = all-ones word):**

| Element | Direction | Operations per address |
|---|---|---|
| M0 | ⇑ | w D |
| M1 | ⇑ | r D, w ~D |
| M2 | ⇑ | r ~D, w D |
| M3 | ⇓ | r D, w ~D |
| M4 | ⇓ | r ~D, w D |
| M5 | ⇑ | r D |

**RUN sequencing**

- Exactly one memory op per cycle, with `mem_en`=1 in every RUN cycle.
- Read-write elements issue the read, then the write, to the same address on consecutive cycles. A 1-bit phase flag selects read or write.
- Address counter:
  - Ascending elements count 0 → N−1; descending elements count N−1 → 0.
  - At the last address of an element, advance the element and load the new start address.
  - No wrap is performed inside an element.

**Compare pipeline**

- A registered copy of the read flag, address, element and expected bit is held for one cycle.
- In the following cycle `mem_rdata` is compared against {DATA_W{exp}}.
- On mismatch:
  - latch `fail`=1, `fail_addr` and `fail_elem`;
  - abort to DONE on the next edge;
  - no further memory ops are issued (`mem_en`=0 from that edge).

**End of sequence**

- After the last M5 read (address N−1), go to CHECK for one cycle. `mem_en`=0 and the final compare happens here.
- Then go to DONE.

**Other rules**

- `busy`=1 in RUN and CHECK only.
- `start` is ignored while `busy`.
- DONE holds the result until the next `start`.
- `rst` asserted at any time forces IDLE immediately and asynchronously, with all outputs at reset values. The memory port is released mid-op; a partial test leaves no result.

**Reset values:** `busy`, `done`, `fail`, `mem_en`, `mem_we` = 0; `fail_addr`, `fail_elem`, `mem_addr`, `mem_wdata` = 0.

## Timing

- Edge 0 samples `start`. RUN occupies cycles 1 … 10N (M0: N, M1–M4: 2N each, M5: N).
- CHECK is cycle 10N+1. `done` is first high at cycle 10N+2, with `busy` low in the same cycle.
- For N=64: 640 memory ops, and `done` rises on the 642nd edge after the start edge.
- Memory outputs are registered and change only on `clk` edges.
- A read at cycle t is compared at cycle t+1. On failure `done` rises at t+2.
- A simultaneous read compare and element transition is legal. The compare uses the pipelined element, not the current one.

## Test plan

- **Fault-free memory** (behavioural RAM, 1-cycle read latency, ADDR_W=6): pulse `start` → `done`=1 at edge 642, `fail`=0, exactly 640 `mem_en` cycles. The address order matches the March C- sequence (M3 starts at 63 and ends at 0).
- **Bit 3 of address 5 stuck-at-0** → `fail`=1, `fail_elem`=2, `fail_addr`=5. No `mem_en` after the abort; `done` is sticky.
- **Address alias** (a write to 10 also writes 11) → `fail`=1, `fail_elem`=1, `fail_addr`=11.
- **Busy and restart:** `start` re-pulsed mid-RUN → ignored and timing unchanged. `start` in DONE after a failure → `fail`/`done` clear on the next edge, and a clean rerun passes.
- **Reset mid-operation:** assert `rst` asynchronously (between edges) at cycle 300 → `mem_en`, `busy` and all outputs go to 0 before the next edge. After deassertion the block sits in IDLE and a new `start` gives a full 642-cycle run.
- **Last-read fault** (address 63 reads a non-zero value only in M5) → failure latched in CHECK, `fail_elem`=5, `fail_addr`=63, `done` at edge 642.

Source files
------------

// File: rtl/mem_march_ctrl.sv
// March C- BIST sequencer: walks six March elements over the whole SRAM,
// checks every read one cycle later and reports the first failing address/element.
module mem_march_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_elem;
  logic              r_ph;
  logic              r_fin;
  logic [2:0]        r_op_elem;
  logic              r_op_exp;

  logic              r_p_rd;
  logic [ADDR_W-1:0] r_p_addr;
  logic [2:0]        r_p_elem;
  logic              r_p_exp;

  logic              w_desc;
  logic              w_single;
  logic              w_op_wr;
  logic              w_exp;
  logic              w_wbit;
  logic              w_addr_end;
  logic              w_miss;
  logic [2:0]        w_next_elem;
  logic [ADDR_W-1:0] w_next_start;

  // M0 and M5 are single-op elements; M1..M4 are read-then-write, selected by r_ph.
  assign w_desc       = (r_elem == 3'd3) || (r_elem == 3'd4);
  assign w_single     = (r_elem == 3'd0) || (r_elem == 3'd5);
  assign w_op_wr      = (r_elem == 3'd0) || (!w_single && r_ph);
  assign w_exp        = (r_elem == 3'd2) || (r_elem == 3'd4);
  assign w_wbit       = (r_elem == 3'd1) || (r_elem == 3'd3);
  assign w_addr_end   = w_desc ? (r_addr == '0) : (r_addr == LAST_ADDR);
  assign w_next_elem  = r_elem + 3'd1;
  assign w_next_start = ((w_next_elem == 3'd3) || (w_next_elem == 3'd4)) ? LAST_ADDR : '0;
  assign w_miss       = r_p_rd && (mem_rdata != {DATA_W{r_p_exp}});

  // Compare stage: describes the op whose read data is on mem_rdata this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_rd   <= 1'b0;
      r_p_addr <= '0;
      r_p_elem <= 3'd0;
      r_p_exp  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of its source.
      r_p_rd   <= mem_en & ~mem_we;
      r_p_addr <= mem_addr;
      r_p_elem <= r_op_elem;
      r_p_exp  <= r_op_exp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_elem    <= 3'd0;
      r_ph      <= 1'b0;
      r_fin     <= 1'b0;
      r_op_elem <= 3'd0;
      r_op_exp  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            r_addr    <= '0;
            r_elem    <= 3'd0;
            r_ph      <= 1'b0;
            r_fin     <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_miss) begin
            r_state   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_addr <= r_p_addr;
            fail_elem <= r_p_elem;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
          end else if (r_fin) begin
            r_state <= S_CHECK;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            mem_en    <= 1'b1;
            mem_we    <= w_op_wr;
            mem_addr  <= r_addr;
            mem_wdata <= {DATA_W{w_wbit}};
            r_op_elem <= r_elem;
            r_op_exp  <= w_exp;
            if (w_single || r_ph) begin
              r_ph <= 1'b0;
              if (w_addr_end) begin
                if (r_elem == 3'd5) begin
                  r_fin <= 1'b1;
                end else begin
                  r_elem <= w_next_elem;
                  r_addr <= w_next_start;
                end
              end else begin
                r_addr <= w_desc ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
              end
            end else begin
              r_ph <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          if (w_miss) begin
            fail      <= 1'b1;
            fail_addr <= r_p_addr;
            fail_elem <= r_p_elem;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_march_ctrl.sv
// Bench for mem_march_ctrl: behavioural 64x8 RAM with injectable faults,
// table-driven runs plus restart and asynchronous-reset sequences.
module tb_mem_march_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int N      = 1 << ADDR_W;
  localparam int OPS    = 10 * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data = '0;

  mem_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (rd_data)
  );

  always #5 clk = ~clk;

  // Fault modes: 0 none, 1 addr5 bit3 stuck-at-0, 2 write to 10 aliases 11,
  // 3 the M5 read of addr 63 (op 640) returns 8'h01.
  int                fault_mode = 0;
  logic              clr_cnt    = 1'b0;
  int                en_cnt     = 0;
  logic [DATA_W-1:0] ram      [0:N-1];
  logic [ADDR_W-1:0] rec_addr [0:OPS-1];
  logic              rec_we   [0:OPS-1];
  logic [DATA_W-1:0] rec_wd   [0:OPS-1];
  logic [ADDR_W-1:0] exp_addr [0:OPS-1];
  logic              exp_we   [0:OPS-1];
  logic [DATA_W-1:0] exp_wd   [0:OPS-1];

  always @(posedge clk) begin
    if (clr_cnt) begin
      en_cnt <= 0;
    end else if (mem_en) begin
      if (en_cnt < OPS) begin
        rec_addr[en_cnt] <= mem_addr;
        rec_we[en_cnt]   <= mem_we;
        rec_wd[en_cnt]   <= mem_wdata;
      end
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        ram[mem_addr] <= (fault_mode == 1 && mem_addr == 6'd5) ? (mem_wdata & 8'hF7) : mem_wdata;
        if (fault_mode == 2 && mem_addr == 6'd10) ram[11] <= mem_wdata;
      end else begin
        rd_data <= (fault_mode == 3 && en_cnt == OPS - 1 && mem_addr == 6'd63) ? 8'h01 : ram[mem_addr];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start is sampled on the edge that follows; returns #1 after that edge (edge 0).
  task automatic pulse_start(input logic clr);
    @(negedge clk);
    start   = 1'b1;
    clr_cnt = clr;
    @(posedge clk);
    #1;
    start   = 1'b0;
    clr_cnt = 1'b0;
  endtask

  // Counts edges after edge 0 until done; optionally re-pulses start at edge pulse_at.
  task automatic run_until_done(input int pulse_at, output int edges);
    edges = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (k == pulse_at)     start = 1'b1;
      if (k == pulse_at + 1) start = 1'b0;
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic build_expected();
    int n = 0;
    for (int a = 0; a < N; a++) begin
      exp_addr[n] = ADDR_W'(a); exp_we[n] = 1'b1; exp_wd[n] = 8'h00; n++;
    end
    for (int e = 1; e <= 4; e++) begin
      for (int j = 0; j < N; j++) begin
        int a;
        a = (e >= 3) ? (N - 1 - j) : j;
        exp_addr[n] = ADDR_W'(a); exp_we[n] = 1'b0; exp_wd[n] = 8'h00; n++;
        exp_addr[n] = ADDR_W'(a); exp_we[n] = 1'b1;
        exp_wd[n] = (e == 1 || e == 3) ? 8'hFF : 8'h00; n++;
      end
    end
    for (int a = 0; a < N; a++) begin
      exp_addr[n] = ADDR_W'(a); exp_we[n] = 1'b0; exp_wd[n] = 8'h00; n++;
    end
  endtask

  typedef struct {
    string name;
    int    fault;
    logic  exp_fail;
    int    exp_elem;
    int    exp_addr;
    int    exp_edge;
    int    exp_ops;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int edges;
    int ops_at_done;
    int seq_err;
    int first_bad;

    // Stuck-at: M2 read of addr 5 is op 203 -> abort edge 205, write at 204 already out.
    // Alias: M1 read of addr 11 is op 87 -> abort edge 89, 88 ops issued.
    vecs[0] = '{"clean",    0, 1'b0, 0,  0, 642, 640};
    vecs[1] = '{"stuck5b3", 1, 1'b1, 2,  5, 205, 204};
    vecs[2] = '{"alias10",  2, 1'b1, 1, 11,  89,  88};
    vecs[3] = '{"last63",   3, 1'b1, 5, 63, 642, 640};
    build_expected();

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, fail, mem_en, mem_we, 3'(fail_elem)}, 32'd0);
    check("reset_addr_data", {fail_addr, mem_addr, mem_wdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      fault_mode = vecs[i].fault;
      pulse_start(1'b1);
      check({vecs[i].name, "_cleared"}, {busy, done, fail}, 32'b100);
      run_until_done(0, edges);
      ops_at_done = en_cnt;
      check({vecs[i].name, "_done_edge"}, edges, vecs[i].exp_edge);
      check({vecs[i].name, "_fail"}, fail, vecs[i].exp_fail);
      check({vecs[i].name, "_fail_elem"}, fail_elem, vecs[i].exp_elem);
      check({vecs[i].name, "_fail_addr"}, fail_addr, vecs[i].exp_addr);
      check({vecs[i].name, "_busy_low"}, busy, 1'b0);
      check({vecs[i].name, "_ops"}, ops_at_done, vecs[i].exp_ops);
      repeat (5) @(posedge clk);
      #1;
      check({vecs[i].name, "_sticky"}, {done, fail}, {1'b1, vecs[i].exp_fail});
      check({vecs[i].name, "_no_ops_after"}, en_cnt, ops_at_done);
      if (vecs[i].fault == 0) begin
        seq_err   = 0;
        first_bad = -1;
        for (int n = 0; n < OPS; n++) begin
          if (rec_addr[n] !== exp_addr[n] || rec_we[n] !== exp_we[n] ||
              (exp_we[n] && rec_wd[n] !== exp_wd[n])) begin
            seq_err++;
            if (first_bad < 0) first_bad = n;
          end
        end
        check("op_sequence_errors", seq_err, 0);
        check("m3_first_op", {rec_addr[320], rec_we[320]}, {6'd63, 1'b0});
        check("m3_last_op", {rec_addr[447], rec_we[447]}, {6'd0, 1'b1});
      end
    end

    // Restart from DONE after a failure, with a stray start mid-run.
    fault_mode = 0;
    pulse_start(1'b1);
    check("restart_clears", {busy, done, fail}, 32'b100);
    run_until_done(100, edges);
    check("restart_done_edge", edges, 642);
    check("restart_pass", {fail, 3'(fail_elem), 6'(fail_addr)}, 32'd0);
    check("restart_ops", en_cnt, 640);

    // Asynchronous reset between edges in the middle of a run.
    pulse_start(1'b1);
    for (int k = 1; k <= 300; k++) @(posedge clk);
    #1;
    check("busy_before_rst", {busy, mem_en}, 32'b11);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {busy, done, fail, mem_en, mem_we}, 32'd0);
    check("rst_async_data", {fail_elem, fail_addr, mem_addr, mem_wdata}, 32'd0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", {busy, done, fail, mem_en}, 32'd0);
    pulse_start(1'b1);
    run_until_done(0, edges);
    check("post_rst_done_edge", edges, 642);
    check("post_rst_pass", fail, 1'b0);
    check("post_rst_ops", en_cnt, 640);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
